// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter for the register file write port (optional WBARB_BYPASS_EN forwarding)
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        reg_wen,
  output logic [ADDR_W-1:0]           rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        wb_busy
`ifdef WBARB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]           byp_addr,
  output logic                        byp_hit,
  output logic [DATA_W-1:0]           byp_data
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Round-robin pointer and write-stage registers
  logic [PTR_W-1:0]  ptr_q,  ptr_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [PTR_W-1:0]  gid_q,  gid_d;

  // Arbitration intermediates
  logic [2*NUM_REQ-1:0] valid_dbl;
  logic [NUM_REQ-1:0]   valid_rot;
  logic                 grant_found;
  logic [PTR_W-1:0]     grant_off;
  logic [PTR_W:0]       grant_sum;
  logic [PTR_W-1:0]     grant_idx;
  logic                 xfer;

  // Selected requester payload
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] data_sel;

  // Rotate valids so ptr sits at bit 0, find the first set bit, then map the offset back to an index
  always_comb begin
    valid_dbl   = {req_valid, req_valid} >> ptr_q;
    valid_rot   = valid_dbl[NUM_REQ-1:0];
    grant_found = 1'b0;
    grant_off   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && valid_rot[i]) begin
        grant_found = 1'b1;
        grant_off   = PTR_W'(i);
      end
    end
    grant_sum = {1'b0, ptr_q} + {1'b0, grant_off};
    if (grant_sum >= (PTR_W+1)'(NUM_REQ)) begin
      grant_sum = grant_sum - (PTR_W+1)'(NUM_REQ);
    end
    grant_idx = grant_sum[PTR_W-1:0];
  end

  // The register file never stalls, so any valid request transfers unless reset is held
  assign xfer = grant_found && !rst;

  // One-hot grant; the decode uses only req_valid, ptr and rst so rd_* never feeds back
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = xfer && (grant_idx == PTR_W'(i));
    end
  end

  // Mux the winning requester's address and data out of the flattened buses
  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        addr_sel = req_addr[i*ADDR_W +: ADDR_W];
        data_sel = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state: capture on transfer and advance ptr past the winner; otherwise hold payload and drop busy
  always_comb begin
    ptr_d  = ptr_q;
    busy_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    gid_d  = gid_q;
    if (xfer) begin
      busy_d = 1'b1;
      addr_d = addr_sel;
      data_d = data_sel;
      gid_d  = grant_idx;
      if (grant_idx == PTR_W'(NUM_REQ-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + PTR_W'(1);
      end
    end
  end

  // State register with synchronous reset; a held write is dropped if reset lands on its presentation edge
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      busy_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      gid_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      addr_q <= addr_d;
      data_q <= data_d;
      gid_q  <= gid_d;
    end
  end

  // Writes to x0 still occupy the stage but never assert the enable
  assign wb_busy  = busy_q;
  assign reg_wen  = busy_q && (addr_q != '0);
  assign rd_addr  = addr_q;
  assign rd_data  = data_q;
  assign grant_id = gid_q;

`ifdef WBARB_BYPASS_EN
  // Forward the value about to land in the register file at the next edge
  assign byp_hit  = reg_wen && (byp_addr == addr_q);
  assign byp_data = byp_hit ? data_q : '0;
`else
  // No forwarding path in this build
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int NR = 3;
  localparam int AW = 6;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              reg_wen;
  logic [AW-1:0]     rd_addr;
  logic [DW-1:0]     rd_data;
  logic [1:0]        grant_id;
  logic              wb_busy;
`ifdef WBARB_BYPASS_EN
  logic [AW-1:0]     byp_addr;
  logic              byp_hit;
  logic [DW-1:0]     byp_data;
`endif

  regfile_wb_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .reg_wen   (reg_wen),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .grant_id  (grant_id),
    .wb_busy   (wb_busy)
`ifdef WBARB_BYPASS_EN
    ,
    .byp_addr  (byp_addr),
    .byp_hit   (byp_hit),
    .byp_data  (byp_data)
`endif
  );

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    gid;
  } wb_exp_t;

  wb_exp_t       exp_q[$];
  logic [DW-1:0] rf_model [0:63];
  int            compared;
  int            mismatched;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: pop one expected write-stage entry each cycle the DUT holds one
  always @(negedge clk) begin
    wb_exp_t e;
    if (wb_busy === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_wb: got wb_busy=1 rd_addr=0x%0h expected no entry", rd_addr);
      end else begin
        e = exp_q.pop_front();
        chk("wb_reg_wen",  64'(reg_wen),  64'(e.wen));
        chk("wb_rd_addr",  64'(rd_addr),  64'(e.addr));
        chk("wb_rd_data",  64'(rd_data),  64'(e.data));
        chk("wb_grant_id", 64'(grant_id), 64'(e.gid));
      end
    end else if (!rst) begin
      chk("idle_reg_wen", 64'(reg_wen), 64'd0);
    end
    if (reg_wen === 1'b1) rf_model[rd_addr] = rd_data;
  end

  // One cycle of stimulus: drive, check grant mid-cycle, queue the expected write-stage entry
  task automatic step(input logic r, input logic [2:0] v,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                      input logic [2:0] exp_rdy);
    logic [AW-1:0] aa [0:2];
    logic [DW-1:0] dd [0:2];
    wb_exp_t e;
    aa[0] = a0; aa[1] = a1; aa[2] = a2;
    dd[0] = d0; dd[1] = d1; dd[2] = d2;
    rst       = r;
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
    @(negedge clk);
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    for (int g = 0; g < 3; g++) begin
      if (exp_rdy[g]) begin
        e.wen  = (aa[g] != '0);
        e.addr = aa[g];
        e.data = dd[g];
        e.gid  = 2'(g);
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 3'b000, '0, '0, '0, '0, '0, '0, 3'b000);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < 64; i++) rf_model[i] = '0;
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
`ifdef WBARB_BYPASS_EN
    byp_addr  = '0;
`endif
    @(posedge clk);
    #1;

    // Reset with all requesters valid: no grants
    step(1'b1, 3'b111, 6'd5, 6'd6, 6'd7, 32'hA, 32'hB, 32'hC, 3'b000);
    step(1'b1, 3'b111, 6'd5, 6'd6, 6'd7, 32'hA, 32'hB, 32'hC, 3'b000);
    chk("rst_reg_wen",  64'(reg_wen),  64'd0);
    chk("rst_rd_addr",  64'(rd_addr),  64'd0);
    chk("rst_rd_data",  64'(rd_data),  64'd0);
    chk("rst_wb_busy",  64'(wb_busy),  64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);

    // Round-robin with all valid
    step(1'b0, 3'b111, 6'd5, 6'd6, 6'd7, 32'hA, 32'hB, 32'hC, 3'b001);
    step(1'b0, 3'b111, 6'd5, 6'd6, 6'd7, 32'hA, 32'hB, 32'hC, 3'b010);
    step(1'b0, 3'b111, 6'd5, 6'd6, 6'd7, 32'hA, 32'hB, 32'hC, 3'b100);
    step(1'b0, 3'b111, 6'd5, 6'd6, 6'd7, 32'hA, 32'hB, 32'hC, 3'b001);
    step(1'b0, 3'b111, 6'd5, 6'd6, 6'd7, 32'hA, 32'hB, 32'hC, 3'b010);
    step(1'b0, 3'b111, 6'd5, 6'd6, 6'd7, 32'hA, 32'hB, 32'hC, 3'b100);

    // Stage drains; payload holds
    idle(1);
    chk("hold_wb_busy",  64'(wb_busy),  64'd0);
    chk("hold_rd_addr",  64'(rd_addr),  64'd7);
    chk("hold_rd_data",  64'(rd_data),  64'hC);
    chk("hold_grant_id", 64'(grant_id), 64'd2);

    // Single requester 2 (ptr=0)
    step(1'b0, 3'b100, '0, '0, 6'd3, '0, '0, 32'hDEADBEEF, 3'b100);
    // x0 write from requester 1 (ptr=0)
    step(1'b0, 3'b010, '0, 6'd0, '0, '0, 32'h1234, '0, 3'b010);
    // Requester 0 alone with ptr=2 wraps; leaves ptr=1
    step(1'b0, 3'b001, 6'd1, '0, '0, 32'h77, '0, '0, 3'b001);
    // Same-address collision with ptr=1
    step(1'b0, 3'b011, 6'd9, 6'd9, '0, 32'h11, 32'h22, '0, 3'b010);
    step(1'b0, 3'b001, 6'd9, '0, '0, 32'h11, '0, '0, 3'b001);
    // ptr=1, requester 1 idle: skip to 2, then 0
    step(1'b0, 3'b101, 6'd10, '0, 6'd11, 32'h100, '0, 32'h200, 3'b100);
    step(1'b0, 3'b001, 6'd10, '0, '0, 32'h100, '0, '0, 3'b001);
    // Write to reg 4 for forwarding
    step(1'b0, 3'b001, 6'd4, '0, '0, 32'h55, '0, '0, 3'b001);
`ifdef WBARB_BYPASS_EN
    req_valid = '0;
    byp_addr  = 6'd4;
    #1;
    chk("byp_hit_match",  64'(byp_hit),  64'd1);
    chk("byp_data_match", 64'(byp_data), 64'h55);
    byp_addr  = 6'd5;
    #1;
    chk("byp_hit_miss",   64'(byp_hit),  64'd0);
    chk("byp_data_miss",  64'(byp_data), 64'd0);
`endif
    idle(3);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("rf_x9_final",   64'(rf_model[9]),  64'h11);
    chk("rf_x3",         64'(rf_model[3]),  64'hDEADBEEF);
    chk("rf_x0_untouched", 64'(rf_model[0]), 64'd0);
    chk("rf_x5",         64'(rf_model[5]),  64'hA);
    chk("rf_x11",        64'(rf_model[11]), 64'h200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
